// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/cmov
// condition codes, CC bit positions and the condition evaluator.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE_DEF = 4'hF;

    // Bit positions inside the {ZF,SF,OF} condition-code vector
    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_t;

    typedef enum logic [3:0] {
        C_YES = 4'd0,
        C_LE  = 4'd1,
        C_L   = 4'd2,
        C_E   = 4'd3,
        C_NE  = 4'd4,
        C_GE  = 4'd5,
        C_G   = 4'd6
    } cond_t;

    // Evaluate a jXX/cmovXX condition against the {ZF,SF,OF} vector
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, lt;
        zf = cc[CC_ZF];
        lt = cc[CC_SF] ^ cc[CC_OF];
        case (fn)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | zf;
            C_L:     cond_eval = lt;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = !zf;
            C_GE:    cond_eval = !lt;
            C_G:     cond_eval = !lt && !zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: r = b OP a, with zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_fun_t         fun,
    output logic [WIDTH-1:0] r,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    // Result and flags; subtraction is b - a as Y86 subq defines it
    always_comb begin
        r  = '0;
        of = 1'b0;
        case (fun)
            ALU_ADD: begin
                r  = b + a;
                of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                r  = b - a;
                of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_AND: r = b & a;
            ALU_XOR: r = b ^ a;
            default: r = '0;
        endcase
        zf = (r == '0);
        sf = r[WIDTH-1];
    end

endmodule

// File: rtl/pipe_execute.sv
// Y86-64 execute stage: operand select, ALU, CC register, condition
// evaluation and the E->M pipeline register with valid/ready handshake.
module pipe_execute
    import y86_pkg::*;
#(
    parameter int unsigned          WIDTH  = 64,
    parameter int unsigned          REG_W  = 4,
    parameter logic [REG_W-1:0]     RNONE  = RNONE_DEF,
    parameter logic [2:0]           CC_RST = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             cc_hold,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic [REG_W-1:0] dstE,
    input  logic [REG_W-1:0] dstM,
    output logic [WIDTH-1:0] e_valE,
    output logic [REG_W-1:0] e_dstE,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [REG_W-1:0] M_dstE,
    output logic [REG_W-1:0] M_dstM,
    output logic [2:0]       cc_q
);

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    alu_fun_t         alu_fun;
    logic             zf, sf, of;
    logic             cnd;
    logic             xfer;

    // ALU operand A: register, immediate, or stack-pointer step
    always_comb begin
        alu_a = '0;
        case (icode)
            I_RRMOVQ, I_OPQ:             alu_a = valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
            I_CALL, I_PUSHQ:             alu_a = '0 - WIDTH'(8);
            I_RET, I_POPQ:               alu_a = WIDTH'(8);
            default:                     alu_a = '0;
        endcase
    end

    // ALU operand B and function select
    always_comb begin
        alu_b   = '0;
        alu_fun = ALU_ADD;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
            default: alu_b = '0;
        endcase
        if (icode == I_OPQ)
            alu_fun = alu_fun_t'(ifun[1:0]);
    end

    y86_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .fun (alu_fun),
        .r   (e_valE),
        .zf  (zf),
        .sf  (sf),
        .of  (of)
    );

    // Condition from the registered CC, plus cmov destination gating and handshake
    always_comb begin
        cnd = 1'b0;
        if (icode == I_RRMOVQ || icode == I_JXX)
            cnd = cond_eval(ifun, cc_q);
        e_dstE   = (icode == I_RRMOVQ && !cnd) ? RNONE : dstE;
        in_ready = !out_valid || out_ready;
        xfer     = in_valid && in_ready;
    end

    // E->M register: flush always empties it, otherwise transfer fills and a taken output drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            M_icode   <= I_NOP;
            M_Cnd     <= 1'b0;
            M_valE    <= '0;
            M_valA    <= '0;
            M_dstE    <= RNONE;
            M_dstM    <= RNONE;
        end else begin
            if (xfer) begin
                M_icode <= icode;
                M_Cnd   <= cnd;
                M_valE  <= e_valE;
                M_valA  <= valA;
                M_dstE  <= e_dstE;
                M_dstM  <= dstM;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (xfer)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    // Condition codes: only an accepted, unsquashed OPq without a pending exception updates them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cc_q <= CC_RST;
        else if (xfer && icode == I_OPQ && !flush && !cc_hold)
            cc_q <= {zf, sf, of};
    end

endmodule

// File: tb/tb_pipe_execute.sv
// Directed self-checking bench for pipe_execute.
module tb_pipe_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        cc_hold;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA, valB, valC;
    logic [3:0]  dstE, dstM;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic [2:0]  cc_q;

    int checks   = 0;
    int failures = 0;

    pipe_execute #(
        .WIDTH  (64),
        .REG_W  (4),
        .RNONE  (4'hF),
        .CC_RST (3'b100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .cc_hold   (cc_hold),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .dstE      (dstE),
        .dstM      (dstM),
        .e_valE    (e_valE),
        .e_dstE    (e_dstE),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .M_icode   (M_icode),
        .M_Cnd     (M_Cnd),
        .M_valE    (M_valE),
        .M_valA    (M_valA),
        .M_dstE    (M_dstE),
        .M_dstM    (M_dstM),
        .cc_q      (cc_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c,
                           input logic [3:0] de, input logic [3:0] dm);
        icode    = ic;
        ifun     = fn;
        valA     = a;
        valB     = b;
        valC     = c;
        dstE     = de;
        dstM     = dm;
        in_valid = 1'b1;
        #1;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input logic [3:0] de, input logic [3:0] dm);
        present(ic, fn, a, b, c, de, dm);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        cc_hold  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; cc_hold = 1'b0; out_ready = 1'b1;
        icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; dstE = 4'hF; dstM = 4'hF;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_M_icode",   {60'd0, M_icode}, 64'd1);
        chk("rst_M_Cnd",     {63'd0, M_Cnd}, 64'd0);
        chk("rst_M_valE",    M_valE, 64'd0);
        chk("rst_M_valA",    M_valA, 64'd0);
        chk("rst_M_dstE",    {60'd0, M_dstE}, 64'hF);
        chk("rst_M_dstM",    {60'd0, M_dstM}, 64'hF);
        chk("rst_cc",        {61'd0, cc_q}, 64'h4);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // addq 2+3 -> 5, flags clear
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h2, 4'hF);
        chk("add_valE",  M_valE, 64'd5);
        chk("add_cc",    {61'd0, cc_q}, 64'h0);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_icode", {60'd0, M_icode}, 64'h6);
        chk("add_valA",  M_valA, 64'd2);
        chk("add_dstE",  {60'd0, M_dstE}, 64'h2);

        // subq 1-1 -> 0, ZF
        present(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
        chk("sub_e_valE", e_valE, 64'd0);
        tick(); in_valid = 1'b0;
        chk("sub_valE", M_valE, 64'd0);
        chk("sub_cc",   {61'd0, cc_q}, 64'h4);

        // signed overflow add -> SF,OF
        send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF);
        chk("ovf_valE", M_valE, 64'h8000_0000_0000_0000);
        chk("ovf_cc",   {61'd0, cc_q}, 64'h3);
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        chk("jl_cnd",   {63'd0, M_Cnd}, 64'd0);
        send(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        chk("jle_cnd",  {63'd0, M_Cnd}, 64'd0);
        send(4'h7, 4'h5, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        chk("jge_cnd",  {63'd0, M_Cnd}, 64'd1);
        chk("jxx_cc",   {61'd0, cc_q}, 64'h3);
        send(4'h7, 4'h7, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
        chk("j7_cnd",   {63'd0, M_Cnd}, 64'd0);

        // cmovne with ZF=1 -> destination suppressed
        send(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
        present(4'h2, 4'h4, 64'h55, 64'h0, 64'd0, 4'h3, 4'hF);
        chk("cmov_e_dstE", {60'd0, e_dstE}, 64'hF);
        chk("cmov_e_valE", e_valE, 64'h55);
        tick(); in_valid = 1'b0;
        chk("cmov_M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("cmov_M_Cnd",  {63'd0, M_Cnd}, 64'd0);
        chk("cmov_M_valE", M_valE, 64'h55);
        // cmovne with ZF=0 -> destination kept
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h2, 4'hF);
        send(4'h2, 4'h4, 64'h55, 64'h0, 64'd0, 4'h3, 4'hF);
        chk("cmov2_M_dstE", {60'd0, M_dstE}, 64'h3);
        chk("cmov2_M_Cnd",  {63'd0, M_Cnd}, 64'd1);

        // stack and address arithmetic
        send(4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF);
        chk("push_valE", M_valE, 64'hF8);
        chk("push_cc",   {61'd0, cc_q}, 64'h0);
        send(4'hB, 4'h0, 64'h0, 64'h100, 64'd0, 4'h4, 4'h6);
        chk("pop_valE",  M_valE, 64'h108);
        send(4'h8, 4'h0, 64'h0, 64'h200, 64'h500, 4'h4, 4'hF);
        chk("call_valE", M_valE, 64'h1F8);
        send(4'h3, 4'h0, 64'h0, 64'h99, 64'h1234, 4'h1, 4'hF);
        chk("irmov_valE", M_valE, 64'h1234);
        send(4'h5, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF, 4'h5);
        chk("mrmov_valE", M_valE, 64'h30);
        chk("mrmov_dstM", {60'd0, M_dstM}, 64'h5);

        // backpressure: xorq held in M while a subq waits
        send(4'h6, 4'h3, 64'hF0, 64'hFF, 64'd0, 4'h2, 4'hF);
        chk("xor_valE", M_valE, 64'h0F);
        out_ready = 1'b0;
        present(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_valE",  M_valE, 64'h0F);
            chk("stall_cc",    {61'd0, cc_q}, 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); in_valid = 1'b0;
        chk("resume_valE", M_valE, 64'd0);
        chk("resume_cc",   {61'd0, cc_q}, 64'h4);
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // cc_hold suppresses the flag update but the op still moves on
        cc_hold = 1'b1;
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h2, 4'hF);
        chk("hold_cc",    {61'd0, cc_q}, 64'h4);
        chk("hold_valE",  M_valE, 64'd5);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        // flush squashes both flags and the valid bit
        flush = 1'b1;
        send(4'h6, 4'h0, 64'd4, 64'd4, 64'd0, 4'h2, 4'hF);
        chk("flush_cc",    {61'd0, cc_q}, 64'h4);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        // flush overrides a stall
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h2, 4'hF);
        chk("pre_fstall_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        chk("fstall_valid", {63'd0, out_valid}, 64'd0);
        flush = 1'b0;
        out_ready = 1'b1;

        // asynchronous reset in the middle of a cycle
        send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'h7);
        chk("pre_rst_cc", {61'd0, cc_q}, 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_cc",    {61'd0, cc_q}, 64'h4);
        chk("mid_rst_icode", {60'd0, M_icode}, 64'd1);
        chk("mid_rst_valE",  M_valE, 64'd0);
        chk("mid_rst_dstE",  {60'd0, M_dstE}, 64'hF);
        chk("mid_rst_dstM",  {60'd0, M_dstM}, 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
